// File: rtl/upuart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package upuart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam int BUSY_WAIT_MAX = 4;

    // Index width for an N-way rotate-priority pick; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upuart_rr_pick.sv
// Combinational round-robin pick: first set bit of valid searching upward from ptr+1 with wrap.
module upuart_rr_pick
    import upuart_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              valid,
    input  logic [idx_width(N)-1:0]   ptr,
    output logic                      found,
    output logic [idx_width(N)-1:0]   idx
);

    localparam int IW = idx_width(N);

    logic [IW-1:0] cand [N];
    logic [N-1:0]  rot;

    // cand[gi] is the requester sitting gi+1 places after the pointer.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IW:0] sum;
        assign sum       = {1'b0, ptr} + (IW+1)'(gi + 1);
        assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
        assign rot[gi]   = valid[cand[gi]];
    end

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/upuart_tx_arb.sv
// Packet-locking round-robin arbiter feeding one UART TX core from NREQ byte streams.
module upuart_tx_arb
    import upuart_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int LOCK_TMO = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [8*NREQ-1:0]            req_data,
    input  logic [NREQ-1:0]              req_last,
    output logic [NREQ-1:0]              req_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_wr,
    input  logic                         tx_busy,
    input  logic                         tx_cts,
    output logic                         grant_vld,
    output logic [idx_width(NREQ)-1:0]   grant_id,
    output logic                         tmo_pulse
);

    localparam int IW = idx_width(NREQ);
    localparam int TW = $clog2(LOCK_TMO + 1);
    localparam int BW = $clog2(BUSY_WAIT_MAX + 1);

    arb_state_t     state;
    logic [IW-1:0]  rr_ptr;
    logic           last_reg;
    logic [TW-1:0]  tmo_cnt;
    logic [BW-1:0]  busy_cnt;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic           send_ok;
    logic           handshake;
    logic [7:0]     data_arr [NREQ];

    upuart_rr_pick #(.N(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign send_ok   = tx_cts && !tx_busy;
    assign handshake = (state == SEND) && req_valid[grant_id] && send_ok;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign data_arr[gi]  = req_data[8*gi +: 8];
        assign req_ready[gi] = (state == SEND) && (grant_id == IW'(gi)) && send_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IW'(NREQ - 1);
            last_reg  <= 1'b0;
            tmo_cnt   <= '0;
            busy_cnt  <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
            tx_data   <= '0;
            tx_wr     <= 1'b0;
            tmo_pulse <= 1'b0;
        end else begin
            tx_wr     <= 1'b0;
            tmo_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        grant_id  <= pick_idx;
                        grant_vld <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        tx_data  <= data_arr[grant_id];
                        tx_wr    <= 1'b1;
                        last_reg <= req_last[grant_id];
                        tmo_cnt  <= '0;
                        busy_cnt <= '0;
                        state    <= WAIT_BUSY;
                    end else if (tx_cts) begin
                        // A CTS stall freezes the timeout; only an idle requester can lose the lock.
                        if (tmo_cnt == TW'(LOCK_TMO - 1)) begin
                            tmo_pulse <= 1'b1;
                            rr_ptr    <= grant_id;
                            grant_vld <= 1'b0;
                            state     <= IDLE;
                        end else if (tmo_cnt != '1) begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                WAIT_BUSY: begin
                    // A core that never raises busy is assumed to have taken the byte.
                    if (tx_busy || busy_cnt == BW'(BUSY_WAIT_MAX - 1)) begin
                        state <= WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + BW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_reg) begin
                            rr_ptr    <= grant_id;
                            grant_vld <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/upuart_tx_arb.md
Name: upuart_tx_arb

Overview:
- Round-robin, packet-locking arbiter that shares one UART transmit core (upuart_tx + its baud generator) among NREQ byte-stream requesters (CPU console, debug monitor, DMA log, ...).
- Sits between requesters and the TX core: grants one requester, forwards one byte per character time, holds the grant until that requester's packet ends.
- Honours CTS flow control; releases a stalled lock after a timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LOCK_TMO, 1024, idle cycles allowed inside a locked packet before forced release (1..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- enable  in  1  when low, no new grant is issued; the byte already in flight completes.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  byte is the final byte of the packet.
- req_ready  out  NREQ  per-requester accept; a transfer occurs when valid & ready.
- tx_data  out  8  byte to the TX core.
- tx_wr  out  1  one-cycle write strobe to the TX core.
- tx_busy  in  1  TX core shifting; rises the cycle after tx_wr and falls after the stop bit.
- tx_cts  in  1  clear-to-send; 1 = peer may receive.
- grant_vld  out  1  a requester holds the lock.
- grant_id  out  clog2(NREQ)  index of the locked requester.
- tmo_pulse  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset: state IDLE; all outputs 0; rr_ptr = NREQ-1, so requester 0 has first priority.
- IDLE:
  - If enable and |req_valid, pick the first valid requester searching from rr_ptr+1 with wrap.
  - Register grant_id, set grant_vld = 1, go SEND; the grant is visible the next cycle.
  - Only valid is sampled for arbitration; last is ignored here.
- SEND:
  - req_ready[grant_id] = !tx_busy & tx_cts (combinational); all other ready bits are 0.
  - On handshake: the next cycle tx_data = byte and tx_wr = 1 for exactly one cycle; latch last; clear tmo_cnt; go WAIT_BUSY.
  - Without a handshake, tmo_cnt increments every cycle.
  - When tmo_cnt reaches LOCK_TMO-1, or the requester drops valid after the first byte and the count expires: pulse tmo_pulse, release the lock (rr_ptr = grant_id, grant_vld = 0), go IDLE.
  - The timeout applies in SEND only and does not count while tx_cts = 0. A CTS stall never forces release.
- WAIT_BUSY: wait for tx_busy = 1, then go WAIT_DONE. If tx_busy does not rise within 4 cycles, treat the byte as sent and go WAIT_DONE.
- WAIT_DONE: wait for tx_busy = 0.
  - If latched last = 1: rr_ptr = grant_id, grant_vld = 0, go IDLE.
  - Otherwise go SEND (lock held).
- Minimum latency: valid seen in IDLE at cycle 0 → grant and ready at cycle 1 → tx_wr at cycle 2.
- Simultaneous requests: round-robin order only; no requester is granted twice while another is waiting between packets.
- enable falls mid-packet: the current byte and the remaining packet complete normally; the gate applies at IDLE only.
- Single-byte packet (valid & last on the first byte) is legal.
- grant_id is stable while grant_vld = 1.
- Reset mid-operation: immediate return to the reset state. A partially sent packet is abandoned, and tx_wr never glitches high.
- tmo_cnt width = clog2(LOCK_TMO+1); it saturates and never wraps.

Decomposition:
- Package upuart_arb_pkg:
  - state enum {IDLE, SEND, WAIT_BUSY, WAIT_DONE};
  - constant BUSY_WAIT_MAX = 4;
  - function for the rotate-priority index width.
- Sub-module upuart_rr_pick: combinational rotate-then-priority-encode of NREQ valids from rr_ptr+1, giving found and index. It is reused by future bus arbiters.

Test Plan:
- Reset, then req_valid = 0001 with byte 0x41 and last = 1 → grant_id = 0 at cycle 1, tx_wr with tx_data = 0x41 at cycle 2, grant_vld = 0 after tx_busy falls.
- All four requesters valid, one single-byte packet each (0x30..0x33) → TX order 0x30, 0x31, 0x32, 0x33; repeated → same order, and rr_ptr returns to 3.
- Requester 1 sends a 3-byte packet (0x10, 0x11, 0x12 with last) while requester 2 is valid → all three bytes go out before any byte from requester 2.
- tx_cts held at 0 for 5000 cycles during SEND → no tx_wr, no tmo_pulse; CTS returns to 1 → byte sent.
- With LOCK_TMO = 16, requester 0 sends 0x55 without last, then drops valid → tmo_pulse exactly 16 cycles after re-entering SEND; requester 3 is granted next.
- Assert rst during WAIT_DONE → all outputs 0 immediately; after release, requester 0 has priority again.
